maze_solver_ctrl: RTL and testbench
===================================

Name: maze_solver_ctrl

Overview:
Depth-first maze-solving controller that sequences the 16x16 one-bit maze memory: rd/wr, x_pos/y_pos, data_in/data_out, where 0 = open and 1 = wall.
- Walks from a start cell to a target cell, marking visited cells by writing 1.
- Keeps the path as a LIFO of moves and backtracks on dead ends.
- Sits between top-level start/done control and the maze memory, and is the memory's only master while busy.

Parameters:
START_X, 0, start column (4 bits)
START_Y, 0, start row (4 bits)
TARGET_X, 15, target column (4 bits)
TARGET_Y, 15, target row (4 bits)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset; same net that resets/reloads the maze memory
start  input  1  one-cycle pulse; starts a solve when idle, ignored while busy
busy  output  1  high from the cycle after start until done/fail
done  output  1  sticky; target reached; cleared by next start or rst
fail  output  1  sticky; no path exists; cleared by next start or rst
path_len  output  8  number of moves on the stack (0..255)
mem_rd  output  1  read strobe to maze memory
mem_wr  output  1  write strobe to maze memory
mem_x  output  4  column address
mem_y  output  4  row address
mem_din  output  1  write data, always 1 (visited mark)
mem_dout  input  1  read data from maze memory

Behaviour:
- Reset values:
  - All outputs 0, state IDLE, stack empty.
  - Current position = (START_X, START_Y).
  - Direction counter dir = 0.
- Memory timing:
  - Read: mem_rd is high for one cycle with the address; mem_dout is sampled in the next cycle.
  - Write: mem_wr is high for one cycle and commits at that edge.
  - mem_rd and mem_wr are never high in the same cycle.
- Directions are 2-bit: RIGHT=0 (x+1), DOWN=1 (y+1), LEFT=2 (x-1), UP=3 (y-1). They are tried in ascending order.
- IDLE:
  - On start: clear done/fail, clear the stack, set pos = start, set dir = 0, go to RDSTART.
- RDSTART: issue a read at pos, then go to CHKSTART.
- CHKSTART: if mem_dout == 1, go to FAIL; otherwise go to MARK.
- MARK:
  - mem_wr = 1 at pos.
  - If pos == target, go to DONE; otherwise go to PROBE.
- PROBE:
  - If the neighbour in dir is out of bounds (x=15 and RIGHT, y=15 and DOWN, x=0 and LEFT, y=0 and UP), go to NEXT with no memory access.
  - Otherwise issue a read at the neighbour and go to CHECK.
- CHECK:
  - mem_dout == 0: push dir, pos = neighbour, dir = 0, go to MARK.
  - mem_dout == 1: go to NEXT.
- NEXT:
  - If dir < 3: dir = dir + 1, go to PROBE.
  - If dir == 3: go to BACK.
- BACK:
  - If the stack is empty, go to FAIL.
  - Otherwise pop d, move pos one step opposite to d, and set dir = d.
  - Then: if d < 3, dir = d + 1 and go to PROBE; if d == 3, stay in BACK.
- DONE / FAIL:
  - busy = 0; the matching sticky flag is set; path_len holds its final value.
  - A new start is accepted from DONE or FAIL.
- path_len always equals the stack occupancy.
  - Push and pop never occur in the same cycle.
  - Overflow is impossible: at most 255 pushes, since every pushed cell is distinct.
- A start that arrives while busy is ignored.
- rst mid-solve aborts immediately to reset state; partial visited marks are discarded by the memory's own reload on rst.
- Address arithmetic is 4-bit. The bounds check happens before any increment or decrement, so wrap-around never occurs.

Optional Feature:
MAZE_PATH_OUT_EN
- Enabled: adds ports dir_out[1:0] (out), dir_valid (out) and dir_ready (in).
  - After DONE, the stack is streamed from bottom (first move) to top.
  - Each transfer happens when dir_valid & dir_ready. dir_valid is held high with dir_out stable until ready.
  - After path_len transfers, dir_valid drops.
  - A new start aborts the stream.
- Disabled: these ports are absent, and the stack needs only top-of-stack access.

Decomposition:
- Package maze_pkg:
  - Direction encoding constants.
  - State enum.
  - WALL=1 and OPEN=0 constants.
  - MAZE_DIM=16, COORD_W=4, STACK_DEPTH=256.
- Sub-module path_stack: 256x2 LIFO with push, pop, top, count[7:0] and (under MAZE_PATH_OUT_EN) an indexed read port.

Test Plan:
- All-open maze, start pulse → path RIGHT x15 then DOWN x15; done=1, fail=0, path_len=30; no mem_rd outside 0..15.
- Wall column at x=1 for y=0..14 (open at (1,15)) → solver goes DOWN 15, RIGHT 15; done=1, path_len=30.
- Target fully enclosed by walls at (14,15) and (15,14) → exhaustive backtrack; fail=1, done=0, path_len=0.
- Start cell (0,0)=1 → fail=1 within 3 cycles of start; no mem_wr issued.
- rst asserted mid-solve at cycle 20 → all outputs 0 in the same cycle (async), state IDLE; a subsequent start on the open maze again gives path_len=30.
- MAZE_PATH_OUT_EN, open maze, dir_ready toggling every other cycle → 30 transfers: fifteen 0s then fifteen 1s; dir_out stable while not ready.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared maze-solver types: direction codes, FSM states, cell coordinates,
// plus the bound-check and one-step neighbour helpers used by the controller.
package maze_pkg;
   localparam int MAZE_DIM    = 16;
   localparam int COORD_W     = 4;
   localparam int STACK_DEPTH = 256;
   localparam int CNT_W       = 8;

   localparam logic WALL = 1'b1;
   localparam logic OPEN = 1'b0;

   typedef logic [1:0] dir_t;
   localparam dir_t DIR_RIGHT = 2'd0;
   localparam dir_t DIR_DOWN  = 2'd1;
   localparam dir_t DIR_LEFT  = 2'd2;
   localparam dir_t DIR_UP    = 2'd3;

   typedef logic [COORD_W-1:0] coord_t;
   typedef struct packed {
      coord_t x;
      coord_t y;
   } pos_t;

   typedef enum logic [3:0] {
      S_IDLE, S_RDSTART, S_CHKSTART, S_MARK, S_PROBE,
      S_CHECK, S_NEXT, S_BACK, S_DONE, S_FAIL
   } state_t;

   function automatic logic off_edge(pos_t p, dir_t d);
      logic r;
      case (d)
         DIR_RIGHT: r = (p.x == coord_t'(MAZE_DIM - 1));
         DIR_DOWN:  r = (p.y == coord_t'(MAZE_DIM - 1));
         DIR_LEFT:  r = (p.x == '0);
         default:   r = (p.y == '0);
      endcase
      return r;
   endfunction

   function automatic pos_t step(pos_t p, dir_t d);
      pos_t n;
      n = p;
      case (d)
         DIR_RIGHT: n.x = p.x + 4'd1;
         DIR_DOWN:  n.y = p.y + 4'd1;
         DIR_LEFT:  n.x = p.x - 4'd1;
         default:   n.y = p.y - 4'd1;
      endcase
      return n;
   endfunction

   // RIGHT<->LEFT and DOWN<->UP differ only in the upper bit.
   function automatic dir_t opposite(dir_t d);
      return d ^ 2'b10;
   endfunction
endpackage

// File: rtl/maze_solver_ctrl_if.sv
// Maze memory bus: one-cycle read strobe (data next cycle), one-cycle write strobe.
interface maze_solver_ctrl_if;
   import maze_pkg::*;
   logic   mem_rd;
   logic   mem_wr;
   coord_t mem_x;
   coord_t mem_y;
   logic   mem_din;
   logic   mem_dout;

   modport master (output mem_rd, mem_wr, mem_x, mem_y, mem_din, input mem_dout);
   modport slave  (input mem_rd, mem_wr, mem_x, mem_y, mem_din, output mem_dout);
endinterface

// File: rtl/maze_solver_ctrl_path_stack.sv
// 256x2 LIFO of moves; count is the occupancy. MAZE_PATH_OUT_EN adds an
// indexed read port so the finished path can be streamed bottom-to-top.
module path_stack
   import maze_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic             pop,
   input  dir_t             push_dat,
   output dir_t             top,
   output logic [CNT_W-1:0] count
`ifdef MAZE_PATH_OUT_EN
   ,
   input  logic [CNT_W-1:0] rd_idx,
   output dir_t             rd_dat
`endif
);
   dir_t mem [STACK_DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       count <= '0;
      else if (clr)  count <= '0;
      else if (push) count <= count + 8'd1;
      else if (pop)  count <= count - 8'd1;
   end

   always_ff @(posedge clk) begin
      if (push) mem[count] <= push_dat;
   end

   assign top = mem[count - 8'd1];

`ifdef MAZE_PATH_OUT_EN
   assign rd_dat = mem[rd_idx];
`endif
endmodule

// File: rtl/maze_solver_ctrl.sv
// Depth-first maze solver driving the 16x16 visited/wall memory from start to target.
// MAZE_PATH_OUT_EN: after done, stream the move stack over a dir_valid/dir_ready port.
module maze_solver_ctrl
   import maze_pkg::*;
#(
   parameter logic [COORD_W-1:0] START_X  = 4'd0,
   parameter logic [COORD_W-1:0] START_Y  = 4'd0,
   parameter logic [COORD_W-1:0] TARGET_X = 4'd15,
   parameter logic [COORD_W-1:0] TARGET_Y = 4'd15
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [CNT_W-1:0] path_len,
`ifdef MAZE_PATH_OUT_EN
   output dir_t             dir_out,
   output logic             dir_valid,
   input  logic             dir_ready,
`endif
   maze_solver_ctrl_if.master maze
);
   localparam pos_t START_POS  = {START_X, START_Y};
   localparam pos_t TARGET_POS = {TARGET_X, TARGET_Y};

   state_t           state, state_nxt;
   pos_t             pos, nbr;
   dir_t             dir, top;
   logic             nbr_off, accept, push, pop, clr, stk_empty;
   logic [CNT_W-1:0] count;

   assign nbr       = step(pos, dir);
   assign nbr_off   = off_edge(pos, dir);
   assign stk_empty = (count == '0);
   assign accept    = start && (state == S_IDLE || state == S_DONE || state == S_FAIL);
   assign path_len  = count;

`ifdef MAZE_PATH_OUT_EN
   logic [CNT_W-1:0] rd_idx;
   dir_t             rd_dat;
`endif

   path_stack u_stack (
      .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop),
      .push_dat(dir), .top(top), .count(count)
`ifdef MAZE_PATH_OUT_EN
      , .rd_idx(rd_idx), .rd_dat(rd_dat)
`endif
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE, S_FAIL: if (start) state_nxt = S_RDSTART;
         S_RDSTART:  state_nxt = S_CHKSTART;
         S_CHKSTART: state_nxt = (maze.mem_dout == WALL) ? S_FAIL : S_MARK;
         S_MARK:     state_nxt = (pos == TARGET_POS) ? S_DONE : S_PROBE;
         S_PROBE:    state_nxt = nbr_off ? S_NEXT : S_CHECK;
         S_CHECK:    state_nxt = (maze.mem_dout == OPEN) ? S_MARK : S_NEXT;
         S_NEXT:     state_nxt = (dir == DIR_UP) ? S_BACK : S_PROBE;
         S_BACK: begin
            if (stk_empty)          state_nxt = S_FAIL;
            else if (top != DIR_UP) state_nxt = S_PROBE;
         end
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      maze.mem_rd = 1'b0;
      maze.mem_wr = 1'b0;
      maze.mem_x  = '0;
      maze.mem_y  = '0;
      push        = 1'b0;
      pop         = 1'b0;
      clr         = accept;
      done        = (state == S_DONE);
      fail        = (state == S_FAIL);
      busy        = !(state == S_IDLE || state == S_DONE || state == S_FAIL);
      case (state)
         S_RDSTART: begin
            maze.mem_rd = 1'b1;
            maze.mem_x  = pos.x;
            maze.mem_y  = pos.y;
         end
         S_MARK: begin
            maze.mem_wr = 1'b1;
            maze.mem_x  = pos.x;
            maze.mem_y  = pos.y;
         end
         S_PROBE: begin
            if (!nbr_off) begin
               maze.mem_rd = 1'b1;
               maze.mem_x  = nbr.x;
               maze.mem_y  = nbr.y;
            end
         end
         S_CHECK: push = (maze.mem_dout == OPEN);
         S_BACK:  pop  = !stk_empty;
         default: ;
      endcase
      maze.mem_din = maze.mem_wr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pos <= START_POS;
         dir <= DIR_RIGHT;
      end else if (accept) begin
         pos <= START_POS;
         dir <= DIR_RIGHT;
      end else begin
         case (state)
            S_CHECK: if (maze.mem_dout == OPEN) begin
               pos <= nbr;
               dir <= DIR_RIGHT;
            end
            S_NEXT: if (dir != DIR_UP) dir <= dir + 2'd1;
            // Undo the popped move; a popped UP has no directions left, so keep unwinding.
            S_BACK: if (!stk_empty) begin
               pos <= step(pos, opposite(top));
               dir <= (top == DIR_UP) ? DIR_UP : top + 2'd1;
            end
            default: ;
         endcase
      end
   end

`ifdef MAZE_PATH_OUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         rd_idx <= '0;
      else if (accept)                 rd_idx <= '0;
      else if (dir_valid && dir_ready) rd_idx <= rd_idx + 8'd1;
   end

   assign dir_valid = (state == S_DONE) && (rd_idx < count);
   assign dir_out   = dir_valid ? rd_dat : DIR_RIGHT;
`endif
endmodule

// File: tb/tb_maze_solver_ctrl.sv
// Randomized and directed mazes checked against a queue-based depth-first reference
// model; with MAZE_PATH_OUT_EN the streamed path is checked too.
module tb_maze_solver_ctrl;
   import maze_pkg::*;

   localparam int BUDGET = 12000;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, fail;
   logic [7:0] path_len;
`ifdef MAZE_PATH_OUT_EN
   logic [1:0] dir_out;
   logic       dir_valid;
   logic       dir_ready = 1'b0;
`endif

   maze_solver_ctrl_if mif ();

   maze_solver_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .fail(fail), .path_len(path_len),
`ifdef MAZE_PATH_OUT_EN
      .dir_out(dir_out), .dir_valid(dir_valid), .dir_ready(dir_ready),
`endif
      .maze(mif)
   );

   always #5 clk = ~clk;

   logic       orig [16][16];
   logic       grid [16][16];
   logic [7:0] wlog [$];
   int         proto_err = 0;
   int         n_checks = 0;
   int         n_err = 0;
   int         dx [4] = '{1, 0, -1, 0};
   int         dy [4] = '{0, 1, 0, -1};
   logic [7:0] m_wlog [$];
   logic [1:0] m_path [$];

   // Maze memory: reloads the loaded maze on rst, read data valid the cycle after mem_rd.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         grid <= orig;
         mif.mem_dout <= 1'b0;
      end else begin
         if (mif.mem_rd) mif.mem_dout <= grid[mif.mem_y][mif.mem_x];
         if (mif.mem_wr) begin
            grid[mif.mem_y][mif.mem_x] <= 1'b1;
            wlog.push_back({mif.mem_x, mif.mem_y});
         end
         if ((mif.mem_rd && mif.mem_wr) || (mif.mem_wr && !mif.mem_din))
            proto_err <= proto_err + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Plain depth-first search from (0,0) to (15,15), directions tried in ascending order.
   task automatic model(output bit m_done, output int m_len);
      bit vis [16][16];
      int x, y, d0, nx, ny, d;
      bit found, fin;
      foreach (vis[i, j]) vis[i][j] = orig[i][j];
      m_wlog.delete();
      m_path.delete();
      x = 0; y = 0; d0 = 0; fin = 0; m_done = 0; m_len = 0;
      if (vis[0][0]) return;
      vis[0][0] = 1;
      m_wlog.push_back({x[3:0], y[3:0]});
      while (!fin) begin
         if (x == 15 && y == 15) begin
            m_done = 1;
            fin = 1;
         end else begin
            found = 0;
            for (int k = d0; k < 4; k++) begin
               if (!found) begin
                  nx = x + dx[k];
                  ny = y + dy[k];
                  if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16 && !vis[ny][nx]) begin
                     found = 1;
                     m_path.push_back(k[1:0]);
                     x = nx; y = ny; d0 = 0;
                     vis[y][x] = 1;
                     m_wlog.push_back({x[3:0], y[3:0]});
                  end
               end
            end
            if (!found) begin
               if (m_path.size() == 0) fin = 1;
               else begin
                  d = int'(m_path.pop_back());
                  x -= dx[d]; y -= dy[d]; d0 = d + 1;
               end
            end
         end
      end
      m_len = m_path.size();
   endtask

   task automatic fill_maze(input int density);
      foreach (orig[i, j]) orig[i][j] = ($urandom_range(0, 99) < density);
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic run_solve(input string tag, input bit poke, output int cycles);
      bit   m_done;
      int   m_len, wbase, pbase, cyc, nbad;
`ifdef MAZE_PATH_OUT_EN
      int         got, bad, unstable, k;
      logic [1:0] prev;
      bit         hold;
`endif
      model(m_done, m_len);
      do_reset();
      wbase = wlog.size();
      pbase = proto_err;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check({tag, "_busy"}, busy, 1);
      cyc = 1;
      while (!(done || fail) && cyc < BUDGET) begin
         start = poke && (cyc == 9) && (m_wlog.size() > 4);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      cycles = cyc;
      check({tag, "_finished"}, done || fail, 1);
      check({tag, "_done"}, done, m_done);
      check({tag, "_fail"}, fail, !m_done);
      check({tag, "_path_len"}, path_len, m_len);
      check({tag, "_idle_busy"}, busy, 0);
      nbad = 0;
      for (int i = 0; i < m_wlog.size(); i++)
         if (wbase + i >= wlog.size() || wlog[wbase + i] !== m_wlog[i]) nbad++;
      check({tag, "_wr_cnt"}, wlog.size() - wbase, m_wlog.size());
      check({tag, "_wr_order"}, nbad, 0);
      check({tag, "_protocol"}, proto_err - pbase, 0);
`ifdef MAZE_PATH_OUT_EN
      if (m_done) begin
         got = 0; bad = 0; unstable = 0; k = 0; hold = 0; prev = 2'd0;
         while (got < m_len && k < 2000) begin
            dir_ready = k[0];
            #1;
            if (hold && dir_out !== prev) unstable++;
            if (dir_valid && dir_ready) begin
               if (dir_out !== m_path[got]) bad++;
               got++;
               hold = 0;
            end else begin
               hold = dir_valid;
               prev = dir_out;
            end
            @(negedge clk);
            k++;
         end
         dir_ready = 1'b0;
         check({tag, "_stream_cnt"}, got, m_len);
         check({tag, "_stream_dirs"}, bad, 0);
         check({tag, "_stream_stable"}, unstable, 0);
         check({tag, "_stream_end"}, dir_valid, 0);
      end
`endif
   endtask

   initial begin
      int cyc;
      foreach (orig[i, j]) orig[i][j] = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_flags", {done, fail}, 0);
      check("rst_path_len", path_len, 0);
      check("rst_mem_strobes", {mif.mem_rd, mif.mem_wr, mif.mem_din}, 0);
      check("rst_mem_addr", {mif.mem_x, mif.mem_y}, 0);
      rst = 1'b0;

      run_solve("open", 1'b0, cyc);
      check("open_len30", path_len, 30);

      // Start from DONE with the maze still marked: start cell now reads as wall.
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check("restart_done_clr", done, 0);
      check("restart_busy", busy, 1);
      check("restart_len_clr", path_len, 0);
      repeat (2) @(negedge clk);
      check("restart_fail", fail, 1);

      foreach (orig[i, j]) orig[i][j] = 1'b0;
      for (int y = 0; y < 15; y++) orig[y][1] = 1'b1;
      run_solve("wall_col", 1'b0, cyc);
      check("wall_col_len30", path_len, 30);

      foreach (orig[i, j]) orig[i][j] = 1'b0;
      orig[15][14] = 1'b1;
      orig[14][15] = 1'b1;
      run_solve("enclosed", 1'b0, cyc);
      check("enclosed_len0", path_len, 0);

      foreach (orig[i, j]) orig[i][j] = 1'b0;
      orig[0][0] = 1'b1;
      run_solve("start_wall", 1'b0, cyc);
      check("start_wall_quick", cyc <= 3, 1);

      foreach (orig[i, j]) orig[i][j] = 1'b0;
      do_reset();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_ctrl", {busy, done, fail, path_len}, 0);
      check("midrst_mem", {mif.mem_rd, mif.mem_wr, mif.mem_x, mif.mem_y}, 0);
      @(negedge clk) rst = 1'b0;
      run_solve("after_rst", 1'b1, cyc);
      check("after_rst_len30", path_len, 30);

      for (int it = 0; it < 8; it++) begin
         fill_maze($urandom_range(10, 35));
         if (it != 5) orig[0][0] = 1'b0;
         if (it % 3 != 2) orig[15][15] = 1'b0;
         run_solve($sformatf("rand%0d", it), 1'b1, cyc);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
